// File: rtl/tl_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_monitor_pkg
// Purpose  : Shared types and constants for the TL in-flight monitor.
// Revision : 1.0 - initial release
// ============================================================================
package tl_monitor_pkg;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_DUP      = 3'd1,
      ERR_ORPHAN   = 3'd2,
      ERR_UNSTABLE = 3'd3,
      ERR_TIMEOUT  = 3'd4
   } err_code_e;

   localparam int c_timeout_default = 1024;

   // Highest-priority violation among those seen in one cycle.
   function automatic err_code_e first_err(input logic dup,
                                           input logic orphan,
                                           input logic unstable,
                                           input logic timeout);
      if (dup)      return ERR_DUP;
      if (orphan)   return ERR_ORPHAN;
      if (unstable) return ERR_UNSTABLE;
      if (timeout)  return ERR_TIMEOUT;
      return ERR_NONE;
   endfunction

endpackage : tl_monitor_pkg
`default_nettype wire

// File: rtl/tl_monitor_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : tl_monitor_watchdog
// Purpose  : Free-running cycle counter with clear/enable and a one-cycle
//            expire pulse when the count reaches TIMEOUT.
// Revision : 1.0 - initial release
// ============================================================================
module tl_monitor_watchdog
   import tl_monitor_pkg::*;
#(
   parameter int TIMEOUT = c_timeout_default
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [15:0] c_limit = 16'(TIMEOUT);

   logic [15:0] r_cnt;

   // Expiry is seen one cycle after the count lands on the limit, and the
   // counter restarts from zero on that same edge.
   assign o_expire = (r_cnt == c_limit);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr || o_expire) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

endmodule : tl_monitor_watchdog
`default_nettype wire

// File: rtl/tl_inflight_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tl_inflight_monitor
// Purpose  : A/D channel protocol monitor: per-source in-flight tracking with
//            duplicate, orphan, A-stability and (optional) timeout checks.
//            Define TL_MONITOR_WATCHDOG_EN to build the response watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module tl_inflight_monitor
   import tl_monitor_pkg::*;
#(
   parameter int SOURCE_W = 3,
   parameter int TIMEOUT  = c_timeout_default
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                a_valid,
   input  logic                a_ready,
   input  logic [SOURCE_W-1:0] a_source,
   input  logic                d_valid,
   input  logic                d_ready,
   input  logic [SOURCE_W-1:0] d_source,
   input  logic                d_last,
   output logic                ok_dup,
   output logic                ok_orphan,
   output logic                ok_stable,
   output logic                ok_timeout,
   output logic [SOURCE_W:0]   inflight_cnt,
   output logic                err_sticky,
   output logic [2:0]          err_code
);

   localparam int c_num_src = 1 << SOURCE_W;

   if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_timeout_range_err
      $error("tl_inflight_monitor: TIMEOUT must be within 2..65535");
   end

   logic [c_num_src-1:0] r_busy;
   logic [c_num_src-1:0] w_busy_nxt;
   logic [SOURCE_W:0]    r_cnt;
   logic                 r_stall;
   logic [SOURCE_W-1:0]  r_stall_src;
   logic                 r_ok_dup;
   logic                 r_ok_orphan;
   logic                 r_ok_stable;
   logic                 r_err_sticky;
   err_code_e            r_err_code;

   logic      w_a_fire;
   logic      w_d_done;
   logic      w_dup;
   logic      w_orphan;
   logic      w_unstable;
   logic      w_expire;
   logic      w_set;
   logic      w_clr;
   logic      w_any_err;
   err_code_e w_first_code;

   assign w_a_fire   = a_valid & a_ready;
   assign w_d_done   = d_valid & d_ready & d_last;
   assign w_dup      = w_a_fire & r_busy[a_source];
   assign w_orphan   = w_d_done & ~r_busy[d_source];
   assign w_unstable = r_stall & (~a_valid | (a_source != r_stall_src));
   assign w_set      = w_a_fire & ~w_dup;
   assign w_clr      = w_d_done & ~w_orphan;

   assign w_any_err    = w_dup | w_orphan | w_unstable | w_expire;
   assign w_first_code = first_err(w_dup, w_orphan, w_unstable, w_expire);

   // A legal set and a legal clear can never target the same source: one
   // needs the bit clear, the other needs it set.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_set) w_busy_nxt[a_source] = 1'b1;
      if (w_clr) w_busy_nxt[d_source] = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_busy       <= '0;
         r_cnt        <= '0;
         r_stall      <= 1'b0;
         r_stall_src  <= '0;
         r_ok_dup     <= 1'b1;
         r_ok_orphan  <= 1'b1;
         r_ok_stable  <= 1'b1;
         r_err_sticky <= 1'b0;
         r_err_code   <= ERR_NONE;
      end else begin
         r_busy      <= w_busy_nxt;
         r_cnt       <= r_cnt + {{SOURCE_W{1'b0}}, w_set}
                              - {{SOURCE_W{1'b0}}, w_clr};
         r_stall     <= a_valid & ~a_ready;
         r_stall_src <= a_source;
         r_ok_dup    <= ~w_dup;
         r_ok_orphan <= ~w_orphan;
         r_ok_stable <= ~w_unstable;
         if (!r_err_sticky && w_any_err) begin
            r_err_sticky <= 1'b1;
            r_err_code   <= w_first_code;
         end
      end
   end

`ifdef TL_MONITOR_WATCHDOG_EN
   logic w_wd_clr;
   logic r_ok_timeout;

   assign w_wd_clr = w_d_done | (r_cnt == '0);

   tl_monitor_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk      (clock),
      .rst      (reset),
      .i_clr    (w_wd_clr),
      .i_en     (~w_wd_clr),
      .o_expire (w_expire)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ok_timeout <= 1'b1;
      end else begin
         r_ok_timeout <= ~w_expire;
      end
   end

   assign ok_timeout = r_ok_timeout;
`else
   assign w_expire   = 1'b0;
   assign ok_timeout = 1'b1;
`endif

   assign ok_dup       = r_ok_dup;
   assign ok_orphan    = r_ok_orphan;
   assign ok_stable    = r_ok_stable;
   assign inflight_cnt = r_cnt;
   assign err_sticky   = r_err_sticky;
   assign err_code     = r_err_code;

endmodule : tl_inflight_monitor
`default_nettype wire

// File: doc/tl_inflight_monitor.md
# tl_inflight_monitor

Protocol monitor for one request/response channel pair (A issue, D response). It tracks in-flight transactions per source ID and checks duplicate issue, orphan response, A-channel stability and response timeout. It sits directly upstream of the single-condition assertion checkers: each `ok_*` output feeds one checker, which ORs it with `reset` and fires `$fatal` plus an obfuscated `$fwrite` when the result is low. It also exports a sticky first-error record for debug readout.

## Interface
- `SOURCE_W`, default 3: source ID width; tracks 2^SOURCE_W IDs.
- `TIMEOUT`, default 1024: watchdog limit in cycles; legal range 2..65535.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  A request valid.
- `a_ready`  in  1  A request ready.
- `a_source`  in  SOURCE_W  A request source ID.
- `d_valid`  in  1  D response valid.
- `d_ready`  in  1  D response ready.
- `d_source`  in  SOURCE_W  D response source ID.
- `d_last`  in  1  final beat of the D response.
- `ok_dup`  out  1  1 = no duplicate-issue violation.
- `ok_orphan`  out  1  1 = no orphan-response violation.
- `ok_stable`  out  1  1 = no A-stability violation.
- `ok_timeout`  out  1  1 = no timeout.
- `inflight_cnt`  out  SOURCE_W+1  number of outstanding sources.
- `err_sticky`  out  1  a violation has occurred since reset.
- `err_code`  out  3  code of the first violation.

## Operation
- Definitions: `a_fire = a_valid & a_ready`; `d_done = d_valid & d_ready & d_last`.
- State:
  - bitmap `busy[2^SOURCE_W]`.
  - counter `inflight_cnt`, range 0..2^SOURCE_W. It never wraps by construction.
  - registered stall flag and source for the previous cycle.
- Duplicate issue: `a_fire` with `busy[a_source]` set.
  - Violation; the bitmap and count are not updated for this request.
- Orphan response: `d_done` with `busy[d_source]` clear.
  - Violation; no update.
  - `busy` is checked against registered state only. A same-cycle `a_fire` and `d_done` on the same source is therefore an orphan; the A set is still applied.
- Legal `a_fire` sets its bit. Legal `d_done` clears its bit.
  - Legal A and D on different sources in the same cycle: both applied.
  - Count changes by the net amount: +1, −1 or 0.
- Stability: if `a_valid & ~a_ready` in cycle N, then cycle N+1 must have `a_valid=1` and the same `a_source`. Otherwise it is a violation.
- Non-last D beats never change state.
- Priority when several violations occur in one cycle, used for `err_code`: DUP(1) > ORPHAN(2) > UNSTABLE(3) > TIMEOUT(4). All applicable `ok_*` outputs still go low together.
- `err_sticky` and `err_code` latch on the first violation and hold until reset. Later violations only pulse `ok_*`.

## Timing
- Detection is registered. A violation sampled at edge N drives its `ok_*` low for exactly one cycle, N→N+1, then the output returns to 1.
- Bitmap and count updates are visible the cycle after the fire.
- Reset values: all `ok_*` = 1, `inflight_cnt` = 0, `busy` = 0, `err_sticky` = 0, `err_code` = 0, stall flag = 0, watchdog = 0.
- Reset mid-transaction clears all in-flight state. A response arriving after reset deasserts is an orphan.
- While `reset` is high, no checks are evaluated and all `ok_*` are held at 1.
- Watchdog:
  - Increments each cycle with `inflight_cnt != 0` and no `d_done`.
  - Clears on `d_done` or when `inflight_cnt == 0`.
  - On reaching TIMEOUT, `ok_timeout` is low for one cycle and the counter clears to 0.

## Configuration
- `TL_MONITOR_WATCHDOG_EN` defined: watchdog instantiated, timeout checking active.
- Not defined:
  - No watchdog logic is generated.
  - `ok_timeout` is tied to 1.
  - `err_code` 4 is unreachable.
  - `TIMEOUT` is ignored.
  - All other behaviour is identical.

## Structure
- Package `tl_monitor_pkg`:
  - `err_code` enum: ERR_NONE=0, ERR_DUP=1, ERR_ORPHAN=2, ERR_UNSTABLE=3, ERR_TIMEOUT=4.
  - `TIMEOUT` default constant.
- Sub-module `tl_monitor_watchdog`:
  - Saturation-free counter with clear and enable inputs and a one-cycle `expire` pulse.
  - Instantiated only under `TL_MONITOR_WATCHDOG_EN`.

## Test plan
- Issue sources 0, 1, 2, then D last for 1 → `inflight_cnt` 1, 2, 3, 2; all `ok_*` stay 1.
- Issue source 5 twice without a response → `ok_dup` low one cycle after the second fire; `err_code` = 1; `inflight_cnt` stays 1.
- D last on idle source 3; also A and D on source 4 in the same cycle → `ok_orphan` pulses for each; after the second, `busy[4]` is set and `inflight_cnt` is 1.
- `a_valid` stalled with source 2, then changed to source 6 while still unaccepted → `ok_stable` low one cycle; `err_code` = 3.
- With `TL_MONITOR_WATCHDOG_EN` and TIMEOUT=16: issue one request, no response → `ok_timeout` low one cycle, 17 cycles after the fire. Without the macro → `ok_timeout` constant 1.
- Assert `reset` with 3 in flight, then send D last for one of them → counts zeroed; `ok_orphan` pulses; `err_sticky` = 1.
